// File: rtl/fsm_trace_pkg.sv
// Shared definitions for the FSM trace driver: controller state codes,
// default vector widths and the index-width helper.
package fsm_trace_pkg;

  localparam int unsigned DEF_IW = 2;
  localparam int unsigned DEF_OW = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_DRST  = 3'd1;
  localparam state_t ST_APPLY = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Width needed to index n entries; never narrower than one bit.
  function automatic int unsigned step_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsm_trace_mem.sv
// Trace storage: one {stimulus, expected output} word per step,
// synchronous write port and asynchronous read port.
module fsm_trace_mem
  import fsm_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IW    = DEF_IW,
  parameter int unsigned OW    = DEF_OW
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [step_w(DEPTH)-1:0]   i_waddr,
  input  logic [IW-1:0]              i_wstim,
  input  logic [OW-1:0]              i_wexp,
  input  logic [step_w(DEPTH)-1:0]   i_raddr,
  output logic [IW-1:0]              o_rstim,
  output logic [OW-1:0]              o_rexp
);

  logic [IW+OW-1:0] r_mem [DEPTH];

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours. The array is deliberately left
  // out of reset: a reset would turn it into DEPTH*(IW+OW) reset flops and
  // the trace contents must survive a controller reset anyway.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= {i_wstim, i_wexp};
    end
  end

  assign {o_rstim, o_rexp} = r_mem[i_raddr];

endmodule

// File: rtl/fsm_trace_driver.sv
// Initiator for 2-in/2-out benchmark FSMs: replays a stored vector trace,
// samples the target output after each vector and scores it against a golden trace.
module fsm_trace_driver
  import fsm_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IW     = DEF_IW,
  parameter int unsigned OW     = DEF_OW,
  parameter int unsigned SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [IW-1:0]              load_stim,
  input  logic [OW-1:0]              load_exp,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [$clog2(DEPTH):0]     mism_cnt,
  output logic                       fsm_rst,
  output logic [IW-1:0]              fsm_in,
  input  logic [OW-1:0]              fsm_out
);

  localparam int unsigned AW = step_w(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned WW = step_w(SETTLE);

  localparam logic [LW-1:0] LEN_MAX   = LW'(DEPTH);
  localparam logic [LW-1:0] MISM_MAX  = '1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(SETTLE - 1);

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   r_last;
  logic [WW-1:0]   r_wait;
  logic            r_empty;
  logic            r_fsm_rst;
  logic [IW-1:0]   r_fsm_in;
  logic [OW-1:0]   r_exp;
  logic            r_pass;
  logic [AW-1:0]   r_fail_idx;
  logic [LW-1:0]   r_mism_cnt;

  logic            w_idle;
  logic            w_start_ok;
  logic            w_we;
  logic            w_last;
  logic            w_mismatch;
  logic [LW-1:0]   w_len_sat;
  logic [AW-1:0]   w_rd_addr;
  logic [IW-1:0]   w_rd_stim;
  logic [OW-1:0]   w_rd_exp;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_start_ok = w_idle & start & ~load_en;
  assign w_we       = w_idle & load_en;
  assign w_len_sat  = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_last     = (r_idx == r_last);
  assign w_mismatch = (fsm_out != r_exp);

  // The read port always looks one step ahead so the next vector and its
  // expected output are loaded on the same edge that begins the step.
  assign w_rd_addr  = (r_state == ST_DRST) ? '0 : r_idx + AW'(1);

  fsm_trace_mem #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .OW    (OW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (load_addr),
    .i_wstim (load_stim),
    .i_wexp  (load_exp),
    .i_raddr (w_rd_addr),
    .o_rstim (w_rd_stim),
    .o_rexp  (w_rd_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_last     <= '0;
      r_wait     <= '0;
      r_empty    <= 1'b0;
      r_fsm_rst  <= 1'b1;
      r_fsm_in   <= '0;
      r_exp      <= '0;
      r_pass     <= 1'b0;
      r_fail_idx <= '0;
      r_mism_cnt <= '0;
    end else begin
      r_fsm_rst <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_fsm_in <= '0;
          if (w_start_ok) begin
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
            r_mism_cnt <= '0;
            r_empty    <= (w_len_sat == '0);
            r_last     <= AW'(w_len_sat - LW'(1));
            // An empty run still passes through DRST, keeping done timing
            // uniform, but the target is never reset for it.
            r_fsm_rst  <= (w_len_sat != '0);
            r_state    <= ST_DRST;
          end
        end

        ST_DRST: begin
          r_idx <= '0;
          if (r_empty) begin
            r_pass  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_fsm_in <= w_rd_stim;
            r_exp    <= w_rd_exp;
            r_state  <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          r_wait  <= WAIT_INIT;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - WW'(1);
          end else begin
            if (w_mismatch) begin
              if (r_mism_cnt == '0) begin
                r_fail_idx <= r_idx;
              end
              if (r_mism_cnt != MISM_MAX) begin
                r_mism_cnt <= r_mism_cnt + LW'(1);
              end
            end
            if (w_last) begin
              r_pass   <= (r_mism_cnt == '0) && !w_mismatch;
              r_fsm_in <= '0;
              r_state  <= ST_DONE;
            end else begin
              r_idx    <= r_idx + AW'(1);
              r_fsm_in <= w_rd_stim;
              r_exp    <= w_rd_exp;
              r_state  <= ST_APPLY;
            end
          end
        end

        ST_DONE: begin
          r_fsm_in <= '0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = !w_idle;
  assign done     = (r_state == ST_DONE);
  assign pass     = r_pass;
  assign fail_idx = r_fail_idx;
  assign mism_cnt = r_mism_cnt;
  assign fsm_rst  = r_fsm_rst;
  assign fsm_in   = r_fsm_in;

endmodule

// File: tb/tb_fsm_trace_driver.sv
// Bench for fsm_trace_driver: two instances (SETTLE=1 and SETTLE=3) share stimulus,
// each drives its own delayed-response target; a scoreboard checks every run.
module tb_fsm_trace_driver;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          load_en   = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [1:0]    load_stim = '0;
  logic [1:0]    load_exp  = '0;
  logic [LW-1:0] len       = '0;
  logic          start     = 1'b0;

  logic [1:0]          busy_w, done_w, pass_w, frst_w;
  logic [1:0][AW-1:0]  fidx_w;
  logic [1:0][LW-1:0]  mism_w;
  logic [1:0][1:0]     fin_w, fout_w;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Target behaviour: a bijective output map seen SETTLE cycles after the input.
  function automatic logic [1:0] tgt_f(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic int unsigned settle_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned ST = (g == 0) ? 1 : 3;
    logic [1:0] pipe [3];

    fsm_trace_driver #(.DEPTH(DEPTH), .IW(2), .OW(2), .SETTLE(ST)) u_dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_stim(load_stim), .load_exp(load_exp), .len(len), .start(start),
      .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]), .fail_idx(fidx_w[g]),
      .mism_cnt(mism_w[g]), .fsm_rst(frst_w[g]), .fsm_in(fin_w[g]), .fsm_out(fout_w[g])
    );

    always @(posedge clk) begin
      if (frst_w[g] === 1'b1) begin
        pipe[0] <= '0;
        pipe[1] <= '0;
        pipe[2] <= '0;
      end else begin
        pipe[0] <= tgt_f(fin_w[g]);
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
      end
    end
    assign fout_w[g] = pipe[ST-1];
  end

  typedef struct {
    int unsigned   due;
    logic          pass;
    logic [AW-1:0] fidx;
    logic [LW-1:0] mism;
    int unsigned   drst;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [1:0]  m_stim [DEPTH];
  logic [1:0]  m_exp  [DEPTH];
  int unsigned rst_pulses [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the oldest expected result for an instance whenever it pulses done.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t        e;
      int unsigned qn;
      qn = (k == 0) ? sb0.size() : sb1.size();
      if (qn != 0) begin
        if (k == 0) e = sb0[0];
        else        e = sb1[0];
      end
      if (rst) rst_pulses[k] = 0;
      else if (busy_w[k] && frst_w[k]) rst_pulses[k]++;
      if (done_w[k] === 1'b1) begin
        if (qn == 0) begin
          check($sformatf("dut%0d unexpected done", k), 32'(done_w[k]), 32'd0);
        end else begin
          if (k == 0) sb0.delete(0);
          else        sb1.delete(0);
          check($sformatf("dut%0d done cycle", k), cyc, e.due);
          check($sformatf("dut%0d pass", k), 32'(pass_w[k]), 32'(e.pass));
          check($sformatf("dut%0d fail_idx", k), 32'(fidx_w[k]), 32'(e.fidx));
          check($sformatf("dut%0d mism_cnt", k), 32'(mism_w[k]), 32'(e.mism));
          check($sformatf("dut%0d fsm_in at done", k), 32'(fin_w[k]), 32'd0);
          check($sformatf("dut%0d fsm_rst pulses", k), rst_pulses[k], e.drst);
        end
        rst_pulses[k] = 0;
      end else if (qn != 0 && cyc > e.due) begin
        check($sformatf("dut%0d done timeout", k), cyc, e.due);
        if (k == 0) sb0.delete(0);
        else        sb1.delete(0);
      end
    end
  end

  task automatic wait_idle();
    int unsigned n = 0;
    while ((busy_w !== 2'b00) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("wait for idle", 32'(busy_w), 32'd0);
  endtask

  task automatic load(input int unsigned a, input logic [1:0] s, input logic [1:0] x);
    wait_idle();
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_stim = s;
    load_exp  = x;
    tick();
    load_en   = 1'b0;
    m_stim[a] = s;
    m_exp[a]  = x;
  endtask

  // Issues a start; the expected outcome comes from the stored trace and the target map.
  task automatic run(input int unsigned n, input bit expect_done);
    exp_t          e;
    int unsigned   ne, mism;
    logic [AW-1:0] fidx;
    wait_idle();
    ne   = (n > DEPTH) ? DEPTH : n;
    mism = 0;
    fidx = '0;
    for (int i = 0; i < ne; i++) begin
      if (tgt_f(m_stim[i]) != m_exp[i]) begin
        if (mism == 0) fidx = AW'(i);
        mism++;
      end
    end
    start = 1'b1;
    len   = LW'(n);
    if (expect_done) begin
      for (int k = 0; k < 2; k++) begin
        e.due  = cyc + 2 + ne * (1 + settle_of(k));
        e.pass = (mism == 0);
        e.fidx = fidx;
        e.mism = (mism > 31) ? 5'd31 : LW'(mism);
        e.drst = (ne > 0) ? 1 : 0;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [1:0]  s;
    int unsigned n;

    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d reset busy", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("dut%0d reset done", k), 32'(done_w[k]), 32'd0);
      check($sformatf("dut%0d reset pass", k), 32'(pass_w[k]), 32'd0);
      check($sformatf("dut%0d reset fail_idx", k), 32'(fidx_w[k]), 32'd0);
      check($sformatf("dut%0d reset mism_cnt", k), 32'(mism_w[k]), 32'd0);
      check($sformatf("dut%0d reset fsm_rst", k), 32'(frst_w[k]), 32'd1);
      check($sformatf("dut%0d reset fsm_in", k), 32'(fin_w[k]), 32'd0);
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d idle fsm_rst", k), 32'(frst_w[k]), 32'd0);
    end

    for (int a = 0; a < DEPTH; a++) begin
      s = 2'($urandom);
      load(a, s, tgt_f(s));
    end
    run(4, 1'b1);

    load(2, m_stim[2], tgt_f(m_stim[2]) ^ 2'b01);
    run(4, 1'b1);
    run(0, 1'b1);
    run(20, 1'b1);

    // Writes and starts while busy must leave memory and the run untouched.
    run(8, 1'b1);
    for (int j = 0; j < 6; j++) begin
      load_en   = 1'b1;
      load_addr = AW'($urandom);
      load_stim = 2'($urandom);
      load_exp  = 2'($urandom);
      start     = j[0];
      len       = LW'($urandom);
      tick();
    end
    load_en = 1'b0;
    start   = 1'b0;
    run(16, 1'b1);

    // start together with load_en: the write lands, the start does not.
    wait_idle();
    s         = 2'($urandom);
    load_en   = 1'b1;
    start     = 1'b1;
    len       = 5'd4;
    load_addr = 4'd5;
    load_stim = s;
    load_exp  = tgt_f(s);
    tick();
    load_en   = 1'b0;
    start     = 1'b0;
    m_stim[5] = s;
    m_exp[5]  = tgt_f(s);
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d start with load ignored", k), 32'(busy_w[k]), 32'd0);
    end

    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(0, 3);
      for (int c = 0; c < n; c++) begin
        s = 2'($urandom);
        load($urandom_range(0, DEPTH - 1), s, ($urandom_range(0, 1) == 1) ? tgt_f(s) : 2'($urandom));
      end
      run($urandom_range(0, 31), 1'b1);
    end

    // Reset during the settle cycle of step 1 (SETTLE=1 instance timing).
    run(6, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d abort busy", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("dut%0d abort fsm_rst", k), 32'(frst_w[k]), 32'd1);
      check($sformatf("dut%0d abort done", k), 32'(done_w[k]), 32'd0);
      check($sformatf("dut%0d abort mism_cnt", k), 32'(mism_w[k]), 32'd0);
      check($sformatf("dut%0d abort fsm_in", k), 32'(fin_w[k]), 32'd0);
    end
    rst = 1'b0;
    repeat (40) tick();

    run(16, 1'b1);

    n = 0;
    while ((sb0.size() + sb1.size()) != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("scoreboard drained", 32'(sb0.size() + sb1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
